// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze move scheduler.
package maze_pkg;

    localparam int MAZE_W_DEF = 20;
    localparam int MAZE_H_DEF = 20;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Target x cell after one step; signed so that x-1 at column 0 becomes -1.
    function automatic logic signed [5:0] step_x(input logic [4:0] x, input dir_t d);
        logic signed [5:0] xs;
        xs = $signed({1'b0, x});
        case (d)
            DIR_LEFT:  return xs - 6'sd1;
            DIR_RIGHT: return xs + 6'sd1;
            default:   return xs;
        endcase
    endfunction

    // Target y cell after one step; signed so that y-1 at row 0 becomes -1.
    function automatic logic signed [5:0] step_y(input logic [4:0] y, input dir_t d);
        logic signed [5:0] ys;
        ys = $signed({1'b0, y});
        case (d)
            DIR_UP:   return ys - 6'sd1;
            DIR_DOWN: return ys + 6'sd1;
            default:  return ys;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    int cand_s;

    // Scan requesters starting at the pointer and stop at the first hit.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = (int'(ptr) + k) % N;
            if (!grant_valid && req[IW'(cand_s)]) begin
                grant_valid           = 1'b1;
                grant[IW'(cand_s)]    = 1'b1;
                grant_idx             = IW'(cand_s);
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/maze_move_scheduler.sv
// Arbitrates agent move requests onto one wall-lookup path and commits legal moves.
module maze_move_scheduler
    import maze_pkg::*;
#(
    parameter int NUM_AGENTS = 2,
    parameter int MAZE_W     = MAZE_W_DEF,
    parameter int MAZE_H     = MAZE_H_DEF,
    parameter int HOME_X     = 1,
    parameter int HOME_Y     = 1,
    parameter int COOLDOWN   = 8
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic [0:MAZE_H-1][MAZE_W-1:0]    maze_in,
    input  logic [NUM_AGENTS-1:0]            move_req,
    input  logic [NUM_AGENTS-1:0][1:0]       move_dir,
    output logic [NUM_AGENTS-1:0]            move_ack,
    output logic [NUM_AGENTS-1:0]            move_ok,
    output logic [NUM_AGENTS-1:0][4:0]       pos_x,
    output logic [NUM_AGENTS-1:0][4:0]       pos_y,
    output logic                             busy
);

    localparam int IW = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1;
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic signed [5:0] W6 = 6'(MAZE_W);
    localparam logic signed [5:0] H6 = 6'(MAZE_H);

    state_t                          state_r, state_s;
    logic [IW-1:0]                   id_r, ptr_r;
    logic signed [5:0]               tgt_x_r, tgt_y_r;
    logic                            blocked_r, blocked_s;
    logic [NUM_AGENTS-1:0]           ack_r, ok_r;
    logic                            busy_r;
    logic [NUM_AGENTS-1:0][4:0]      pos_x_r, pos_y_r;
    logic [NUM_AGENTS-1:0][CW-1:0]   cool_r;
    logic [NUM_AGENTS-1:0]           elig_s, grant_s;
    logic [IW-1:0]                   grant_idx_s;
    logic                            grant_valid_s;

    assign move_ack = ack_r;
    assign move_ok  = ok_r;
    assign pos_x    = pos_x_r;
    assign pos_y    = pos_y_r;
    assign busy     = busy_r;

    // An agent may compete only while requesting and out of cooldown.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_AGENTS; i++) begin
            elig_s[IW'(i)] = move_req[IW'(i)] && (cool_r[IW'(i)] == '0);
        end
    end

    rr_arbiter #(.N(NUM_AGENTS), .IW(IW)) u_arb (
        .req         (elig_s),
        .ptr         (ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Next-state logic for the IDLE -> CHECK -> COMMIT sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK:   state_s = COMMIT;
            COMMIT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Target legality: bounds first so the maze is only indexed in range, then walls, then agents.
    always_comb begin
        blocked_s = 1'b0;
        if ((tgt_x_r < 6'sd0) || (tgt_x_r >= W6) || (tgt_y_r < 6'sd0) || (tgt_y_r >= H6)) begin
            blocked_s = 1'b1;
        end else if (maze_in[tgt_y_r[4:0]][tgt_x_r[4:0]]) begin
            blocked_s = 1'b1;
        end else begin
            blocked_s = 1'b0;
        end
        for (int j = 0; j < NUM_AGENTS; j++) begin
            if ((IW'(j) != id_r) &&
                ($signed({1'b0, pos_x_r[IW'(j)]}) == tgt_x_r) &&
                ($signed({1'b0, pos_y_r[IW'(j)]}) == tgt_y_r)) begin
                blocked_s = 1'b1;
            end else begin
                blocked_s = blocked_s;
            end
        end
    end

    // FSM state, transaction latches, committed positions and response pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= IDLE;
            id_r      <= '0;
            ptr_r     <= '0;
            tgt_x_r   <= 6'sd0;
            tgt_y_r   <= 6'sd0;
            blocked_r <= 1'b0;
            ack_r     <= '0;
            ok_r      <= '0;
            busy_r    <= 1'b0;
            for (int i = 0; i < NUM_AGENTS; i++) begin
                pos_x_r[IW'(i)] <= 5'(HOME_X + 2 * i);
                pos_y_r[IW'(i)] <= 5'(HOME_Y);
            end
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            ack_r   <= '0;
            ok_r    <= '0;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        id_r    <= grant_idx_s;
                        tgt_x_r <= step_x(pos_x_r[grant_idx_s], dir_t'(move_dir[grant_idx_s]));
                        tgt_y_r <= step_y(pos_y_r[grant_idx_s], dir_t'(move_dir[grant_idx_s]));
                    end
                end
                CHECK: begin
                    blocked_r <= blocked_s;
                end
                COMMIT: begin
                    if (!blocked_r) begin
                        pos_x_r[id_r] <= tgt_x_r[4:0];
                        pos_y_r[id_r] <= tgt_y_r[4:0];
                    end
                    ack_r[id_r] <= 1'b1;
                    ok_r[id_r]  <= ~blocked_r;
                    ptr_r       <= (id_r == IW'(NUM_AGENTS - 1)) ? '0 : id_r + IW'(1);
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Per-agent cooldown: load on an accepted move, otherwise count down to zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cool_r <= '0;
        end else begin
            for (int i = 0; i < NUM_AGENTS; i++) begin
                if ((state_r == COMMIT) && !blocked_r && (id_r == IW'(i))) begin
                    cool_r[IW'(i)] <= CW'(COOLDOWN);
                end else if (cool_r[IW'(i)] != '0) begin
                    cool_r[IW'(i)] <= cool_r[IW'(i)] - CW'(1);
                end else begin
                    cool_r[IW'(i)] <= cool_r[IW'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_maze_move_scheduler.sv
// Bench for maze_move_scheduler: scenario tasks plus randomized moves against a cell-level model.
module tb_maze_move_scheduler;

    localparam int CD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [0:19][19:0]    maze, maze0;
    logic [1:0]           req, req0;
    logic [1:0][1:0]      dir, dir0;
    logic [1:0]           ack, ok, ack0, ok0;
    logic [1:0][4:0]      px, py, px0, py0;
    logic                 busy, busy0;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    // Model state: committed cells and earliest grant cycle for each agent.
    int m_x[2], m_y[2], m_ready[2];
    int m0_x[2], m0_y[2];

    // Count rising edges so latency can be predicted in absolute cycles.
    always @(posedge clk) cyc <= cyc + 1;

    maze_move_scheduler #(.NUM_AGENTS(2), .COOLDOWN(CD)) dut (
        .Clk(clk), .Reset_n(rst_n), .maze_in(maze), .move_req(req), .move_dir(dir),
        .move_ack(ack), .move_ok(ok), .pos_x(px), .pos_y(py), .busy(busy)
    );

    maze_move_scheduler #(.NUM_AGENTS(2), .COOLDOWN(0)) dut0 (
        .Clk(clk), .Reset_n(rst_n), .maze_in(maze0), .move_req(req0), .move_dir(dir0),
        .move_ack(ack0), .move_ok(ok0), .pos_x(px0), .pos_y(py0), .busy(busy0)
    );

    function automatic void step(input int x, input int y, input logic [1:0] d,
                                 output int tx, output int ty);
        tx = x; ty = y;
        case (d)
            2'd0:    ty = y - 1;
            2'd1:    ty = y + 1;
            2'd2:    tx = x - 1;
            default: tx = x + 1;
        endcase
    endfunction

    function automatic bit is_blocked(input int tx, input int ty, input int a,
                                      input int xs[2], input int ys[2],
                                      input logic [0:19][19:0] m);
        if (tx < 0 || tx >= 20 || ty < 0 || ty >= 20) return 1'b1;
        if (m[ty[4:0]][tx[4:0]]) return 1'b1;
        for (int j = 0; j < 2; j++)
            if (j != a && xs[j] == tx && ys[j] == ty) return 1'b1;
        return 1'b0;
    endfunction

    task automatic init_maze(output logic [0:19][19:0] m, input bit rnd);
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 20; x++)
                if (x == 0 || y == 0 || x == 19 || y == 19) m[y][x] = 1'b1;
                else m[y][x] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic model_home();
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 1 + 2 * i; m_y[i] = 1; m_ready[i] = 0;
            m0_x[i] = 1 + 2 * i; m0_y[i] = 1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 2'b00; req0 = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_home();
    endtask

    // One request on dut, checked for timing, ack vector, verdict and resulting cell.
    task automatic do_move(input bit a, input logic [1:0] d, input bit drop_early, input string name);
        int tx, ty, c, g, e, t;
        bit exp_blk;
        logic [1:0] exp_ack;
        step(m_x[a], m_y[a], d, tx, ty);
        exp_blk = is_blocked(tx, ty, a, m_x, m_y, maze);
        c = cyc;
        g = (c + 1 > m_ready[a]) ? c + 1 : m_ready[a];
        e = g + 2;
        exp_ack = 2'b00; exp_ack[a] = 1'b1;
        dir[a] = d; req[a] = 1'b1;
        t = 0;
        do begin
            @(negedge clk); t++;
            if (drop_early && cyc == g) req[a] = 1'b0;
        end while (ack === 2'b00 && t < 60);
        req[a] = 1'b0;
        n_total++;
        if (ack !== exp_ack || cyc != e)
            $display("FAIL %s ack: got ack=%b at cycle %0d, want ack=%b at cycle %0d", name, ack, cyc, exp_ack, e);
        else n_pass++;
        n_total++;
        if (ok[a] !== !exp_blk) $display("FAIL %s ok: got %b want %b", name, ok[a], !exp_blk);
        else n_pass++;
        if (!exp_blk) begin
            m_x[a] = tx; m_y[a] = ty; m_ready[a] = e + CD + 1;
        end
        n_total++;
        if (int'(px[a]) != m_x[a] || int'(py[a]) != m_y[a])
            $display("FAIL %s pos: got (%0d,%0d) want (%0d,%0d)", name, px[a], py[a], m_x[a], m_y[a]);
        else n_pass++;
    endtask

    task automatic test_reset();
        bit saw_ack;
        rst_n = 1'b0; req = 2'b00; req0 = 2'b00; dir = '0; dir0 = '0;
        init_maze(maze, 1'b0); init_maze(maze0, 1'b1);
        model_home();
        repeat (2) @(negedge clk);
        n_total++;
        if (px !== {5'd3, 5'd1} || py !== {5'd1, 5'd1} || ack !== 2'b00 || ok !== 2'b00 || busy !== 1'b0)
            $display("FAIL reset_state: px=%h py=%h ack=%b ok=%b busy=%b", px, py, ack, ok, busy);
        else n_pass++;
        n_total++;
        if (px0 !== {5'd3, 5'd1} || py0 !== {5'd1, 5'd1} || ack0 !== 2'b00 || busy0 !== 1'b0)
            $display("FAIL reset_state0: px=%h py=%h ack=%b busy=%b", px0, py0, ack0, busy0);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        dir[0] = 2'd3; req[0] = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL busy_in_check: got %b want 1", busy);
        else n_pass++;
        rst_n = 1'b0; req[0] = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0 || ack !== 2'b00 || px[0] !== 5'd1)
            $display("FAIL reset_mid_check: busy=%b ack=%b px0=%0d want 0,00,1", busy, ack, px[0]);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        saw_ack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack !== 2'b00) saw_ack = 1'b1;
        end
        n_total++;
        if (saw_ack || px[0] !== 5'd1 || py[0] !== 5'd1)
            $display("FAIL aborted_txn: saw_ack=%b pos=(%0d,%0d) want 0,(1,1)", saw_ack, px[0], py[0]);
        else n_pass++;
        model_home();
    endtask

    task automatic test_move_cooldown();
        do_move(1'b0, 2'd3, 1'b0, "move_right");
        n_total++;
        if (busy !== 1'b0) $display("FAIL busy_after_ack: got %b want 0", busy);
        else n_pass++;
        do_move(1'b0, 2'd1, 1'b0, "cooldown_down");
    endtask

    task automatic test_collision();
        do_move(1'b0, 2'd0, 1'b0, "back_up");
        do_move(1'b0, 2'd3, 1'b0, "agent_collide");
    endtask

    task automatic test_drop_req();
        bit extra;
        do_move(1'b1, 2'd1, 1'b1, "drop_early");
        extra = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack !== 2'b00) extra = 1'b1;
        end
        n_total++;
        if (extra) $display("FAIL drop_no_second: extra ack seen, want none");
        else n_pass++;
    endtask

    task automatic test_wall_bounds();
        apply_reset();
        do_move(1'b0, 2'd0, 1'b0, "wall_up");
        maze[1][0] = 1'b0;
        do_move(1'b0, 2'd2, 1'b0, "open_left");
        do_move(1'b0, 2'd2, 1'b0, "bound_left");
    endtask

    task automatic test_alternate();
        int last, t, tx, ty, a;
        bit exp_blk;
        last = cyc;
        dir0[0] = 2'($urandom_range(0, 3)); dir0[1] = 2'($urandom_range(0, 3));
        req0 = 2'b11;
        for (int k = 0; k < 12; k++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (ack0 === 2'b00 && t < 10);
            a = k % 2;
            n_total++;
            if (ack0 !== (a == 0 ? 2'b01 : 2'b10) || cyc != last + 3)
                $display("FAIL alternate_%0d: ack=%b at %0d, want agent %0d at %0d", k, ack0, cyc, a, last + 3);
            else n_pass++;
            last = cyc;
            step(m0_x[a], m0_y[a], dir0[a], tx, ty);
            exp_blk = is_blocked(tx, ty, a, m0_x, m0_y, maze0);
            if (!exp_blk) begin m0_x[a] = tx; m0_y[a] = ty; end
            n_total++;
            if (ok0[a] !== !exp_blk || int'(px0[a]) != m0_x[a] || int'(py0[a]) != m0_y[a])
                $display("FAIL alternate_res_%0d: ok=%b pos=(%0d,%0d) want %b (%0d,%0d)",
                         k, ok0[a], px0[a], py0[a], !exp_blk, m0_x[a], m0_y[a]);
            else n_pass++;
            dir0[a] = 2'($urandom_range(0, 3));
        end
        req0 = 2'b00;
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 4) == 0) init_maze(maze, 1'b1);
            do_move(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_move_cooldown();
        test_collision();
        test_drop_req();
        test_wall_bounds();
        test_alternate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
